// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register family.
package pipe_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int DATA_W_DEF = 32;

  // An all-zero payload is decoded by every downstream stage as a NOP bubble.
  typedef logic [DATA_W_DEF-1:0] nop_word_t;
  localparam nop_word_t NOP = '0;

  // One pipeline slot at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [PC_W_DEF-1:0]   pc;
    logic [DATA_W_DEF-1:0] data;
  } pipe_entry_t;

endpackage : pipe_pkg

// File: rtl/pipe_skid_slot.sv
// Skid entry S: holds the one entry that arrives while the main register
// cannot advance, so upstream ready can come straight from a flop.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              take,
  input  logic [PC_W-1:0]   load_pc,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP);

  // Load wins over take: when M drains S and a new entry arrives in the
  // same cycle, the new entry replaces the old one in S.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= BUBBLE_DATA;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= BUBBLE_DATA;
    end
  end

endmodule : pipe_skid_slot

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall, flush, ready/valid
// handshake, optional skid entry and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP);

  logic              m_valid;
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_data;

  logic              s_valid;
  logic [PC_W-1:0]   s_pc;
  logic [DATA_W-1:0] s_data;

  logic adv;
  logic acc;
  logic s_load;
  logic s_take;

  // Handshake decode: when M may advance, whether an entry is taken, and
  // where it lands. With the skid present, in_ready comes only from s_valid.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    adv      = !stall && (!m_valid || out_ready);
    in_ready = SKID_EN ? !s_valid : adv;
    acc      = in_valid && in_ready && !flush;
    s_take   = adv && s_valid;
    // Input goes to S when M is held, or when M is refilled from S.
    s_load   = acc && (s_valid ? adv : !adv);
  end

  if (SKID_EN) begin : g_skid
    pipe_skid_slot #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .load      (s_load),
      .take      (s_take),
      .load_pc   (in_pc),
      .load_data (in_data),
      .valid     (s_valid),
      .pc        (s_pc),
      .data      (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_pc    = '0;
    assign s_data  = BUBBLE_DATA;
  end

  // Main entry M: refilled from S first to keep FIFO order, otherwise from
  // the input, otherwise turned into a zero bubble; held while not advancing.
  // NOTE: pc/data are cleared along with valid so an empty slot always reads as a NOP.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_data  <= BUBBLE_DATA;
    end else if (adv) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_pc    <= s_pc;
        m_data  <= s_data;
      end else if (acc) begin
        m_valid <= 1'b1;
        m_pc    <= in_pc;
        m_data  <= in_data;
      end else begin
        m_valid <= 1'b0;
        m_pc    <= '0;
        m_data  <= BUBBLE_DATA;
      end
    end
  end

  // Stall counter: counts stalled cycles that hold a real entry, saturating;
  // only reset clears it so it survives flushes for performance debug.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && m_valid && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_pc    = m_pc;
  assign out_data  = m_data;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: cycle-exact vector table on the
// default build, counter saturation and the combinational-ready build, then
// a random run checked against per-instance scoreboards.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst, fl, st, iv, ordy;
  logic [31:0] ipc, idata;

  // Default build: skid present, 16-bit counter.
  logic        m_ir, m_ov;
  logic [31:0] m_opc, m_odata;
  logic [15:0] m_cnt;
  // Skid present, 4-bit counter.
  logic        c_ir, c_ov;
  logic [31:0] c_opc, c_odata;
  logic [3:0]  c_cnt;
  // No skid, 4-bit counter.
  logic        n_ir, n_ov;
  logic [31:0] n_opc, n_odata;
  logic [3:0]  n_cnt;

  pipe_stage_reg dut (
    .clk(clk), .reset(rst), .flush(fl), .stall(st), .in_valid(iv), .in_ready(m_ir),
    .in_pc(ipc), .in_data(idata), .out_valid(m_ov), .out_ready(ordy),
    .out_pc(m_opc), .out_data(m_odata), .stall_cnt(m_cnt)
  );

  pipe_stage_reg #(.SKID_EN(1'b1), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(rst), .flush(fl), .stall(st), .in_valid(iv), .in_ready(c_ir),
    .in_pc(ipc), .in_data(idata), .out_valid(c_ov), .out_ready(ordy),
    .out_pc(c_opc), .out_data(c_odata), .stall_cnt(c_cnt)
  );

  pipe_stage_reg #(.SKID_EN(1'b0), .CNT_W(4)) dut_ns (
    .clk(clk), .reset(rst), .flush(fl), .stall(st), .in_valid(iv), .in_ready(n_ir),
    .in_pc(ipc), .in_data(idata), .out_valid(n_ov), .out_ready(ordy),
    .out_pc(n_opc), .out_data(n_odata), .stall_cnt(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, fl, st, iv;
    logic [31:0] pc, data;
    logic        ordy;
    logic        ev;
    logic [31:0] epc, edata;
    logic        eir;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                              input logic [31:0] pc, input logic [31:0] data, input logic o,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ed,
                              input logic eir, input logic [15:0] ecnt);
    vec_t x;
    x.rst = r; x.fl = f; x.st = s; x.iv = v; x.pc = pc; x.data = data; x.ordy = o;
    x.ev = ev; x.epc = epc; x.edata = ed; x.eir = eir; x.ecnt = ecnt;
    return x;
  endfunction

  function automatic logic [31:0] dv(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  pipe_entry_t q_m[$];
  pipe_entry_t q_n[$];

  // Scoreboard step, called at the negedge with inputs and outputs settled.
  task automatic score();
    pipe_entry_t e;
    check("m_bubble_zero", m_ov || (m_opc == 0 && m_odata == 0), 1);
    check("n_bubble_zero", n_ov || (n_opc == 0 && n_odata == 0), 1);
    check("m_occupancy", q_m.size() <= 2, 1);
    check("n_out_valid", n_ov, q_n.size() != 0);
    check("n_in_ready", n_ir, !st && (!n_ov || ordy));
    if (fl) begin
      q_m.delete();
      q_n.delete();
    end else begin
      if (m_ov && ordy && !st) begin
        if (q_m.size() == 0) check("m_spurious_output", 1, 0);
        else begin
          e = q_m.pop_front();
          check("m_sb_pc", m_opc, e.pc);
          check("m_sb_data", m_odata, e.data);
        end
      end
      if (n_ov && ordy && !st) begin
        if (q_n.size() == 0) check("n_spurious_output", 1, 0);
        else begin
          e = q_n.pop_front();
          check("n_sb_pc", n_opc, e.pc);
          check("n_sb_data", n_odata, e.data);
        end
      end
      e.valid = 1'b1; e.pc = ipc; e.data = idata;
      if (iv && m_ir) q_m.push_back(e);
      if (iv && n_ir) q_n.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; fl = 1'b0; st = 1'b0; iv = 1'b0; ordy = 1'b1; ipc = '0; idata = '0;
  endtask

  initial begin
    logic [31:0] pc_seq;
    int          sat;

    idle_inputs();
    rst = 1'b1;

    // Cycle-exact table for the default build.
    vecs.push_back(mk(1,0,0,0, 32'h0,   32'h0,          1, 0, 32'h0,   32'h0,          1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h100, 32'h2002_0005,  1, 1, 32'h100, 32'h2002_0005,  1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h180, dv(32'h180),    1, 1, 32'h180, dv(32'h180),    1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h184, dv(32'h184),    1, 1, 32'h184, dv(32'h184),    1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h188, dv(32'h188),    1, 1, 32'h188, dv(32'h188),    1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h18C, dv(32'h18C),    1, 1, 32'h18C, dv(32'h18C),    1, 0));
    vecs.push_back(mk(0,0,0,1, 32'h104, dv(32'h104),    1, 1, 32'h104, dv(32'h104),    1, 0));
    vecs.push_back(mk(0,0,1,1, 32'h108, dv(32'h108),    1, 1, 32'h104, dv(32'h104),    0, 1));
    vecs.push_back(mk(0,0,1,1, 32'h10C, dv(32'h10C),    1, 1, 32'h104, dv(32'h104),    0, 2));
    vecs.push_back(mk(0,0,1,1, 32'h10C, dv(32'h10C),    1, 1, 32'h104, dv(32'h104),    0, 3));
    vecs.push_back(mk(0,0,0,1, 32'h10C, dv(32'h10C),    1, 1, 32'h108, dv(32'h108),    1, 3));
    vecs.push_back(mk(0,0,0,1, 32'h10C, dv(32'h10C),    1, 1, 32'h10C, dv(32'h10C),    1, 3));
    vecs.push_back(mk(0,0,0,1, 32'h200, dv(32'h200),    1, 1, 32'h200, dv(32'h200),    1, 3));
    vecs.push_back(mk(0,0,0,1, 32'h204, dv(32'h204),    0, 1, 32'h200, dv(32'h200),    0, 3));
    vecs.push_back(mk(0,1,0,1, 32'h208, dv(32'h208),    1, 0, 32'h0,   32'h0,          1, 3));
    vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,          1, 0, 32'h0,   32'h0,          1, 3));
    vecs.push_back(mk(0,1,0,1, 32'h20C, dv(32'h20C),    1, 0, 32'h0,   32'h0,          1, 3));
    vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,          1, 0, 32'h0,   32'h0,          1, 3));
    vecs.push_back(mk(0,0,0,1, 32'h300, dv(32'h300),    1, 1, 32'h300, dv(32'h300),    1, 3));
    vecs.push_back(mk(0,0,0,1, 32'h304, dv(32'h304),    0, 1, 32'h300, dv(32'h300),    0, 3));
    vecs.push_back(mk(1,0,1,1, 32'h308, dv(32'h308),    1, 0, 32'h0,   32'h0,          1, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,          1, 0, 32'h0,   32'h0,          1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; fl = vecs[i].fl; st = vecs[i].st; iv = vecs[i].iv;
      ipc = vecs[i].pc; idata = vecs[i].data; ordy = vecs[i].ordy;
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), m_ov,    vecs[i].ev);
      check($sformatf("vec%0d out_pc", i),    m_opc,   vecs[i].epc);
      check($sformatf("vec%0d out_data", i),  m_odata, vecs[i].edata);
      check($sformatf("vec%0d in_ready", i),  m_ir,    vecs[i].eir);
      check($sformatf("vec%0d stall_cnt", i), m_cnt,   vecs[i].ecnt);
    end

    // Counter saturation on the 4-bit builds, combinational ready without skid.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check("sat reset c_cnt", c_cnt, 0);
    check("sat reset n_out_valid", n_ov, 0);
    rst = 1'b0; iv = 1'b1; ipc = 32'h400; idata = dv(32'h400);
    @(posedge clk); #1;
    check("sat load c_out_valid", c_ov, 1);
    check("sat load n_out_valid", n_ov, 1);
    st = 1'b1; ipc = 32'h404; idata = dv(32'h404);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("sat%0d n_in_ready", i), n_ir, !st && (!n_ov || ordy));
      @(posedge clk); #1;
      sat = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("sat%0d c_cnt", i), c_cnt, sat);
      check($sformatf("sat%0d n_cnt", i), n_cnt, sat);
      check($sformatf("sat%0d m_cnt", i), m_cnt, i + 1);
      check($sformatf("sat%0d c_out_pc", i), c_opc, 32'h400);
      check($sformatf("sat%0d n_out_pc", i), n_opc, 32'h400);
    end

    // Random traffic against the scoreboards.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pc_seq = 32'h1000;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      fl    = ($urandom_range(0, 49) == 0);
      st    = ($urandom_range(0, 4) == 0);
      ordy  = ($urandom_range(0, 3) != 0);
      iv    = ($urandom_range(0, 9) < 7);
      ipc   = pc_seq;
      idata = $urandom;
      pc_seq = pc_seq + 32'd4;
      @(negedge clk);
      score();
      @(posedge clk); #1;
    end

    // Drain and confirm nothing was lost.
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      score();
      @(posedge clk); #1;
    end
    check("drain m_queue_empty", q_m.size(), 0);
    check("drain n_queue_empty", q_n.size(), 0);
    check("drain m_out_valid", m_ov, 0);
    check("drain n_out_valid", n_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register: the generalised successor of the fixed 32-bit PC/instruction stage register.
- Carries a PC and a payload word with a valid bit.
- Supports hazard stall, flush, and a ready/valid handshake, with an optional 2-entry skid buffer that breaks the upstream ready path.
- Counts stall cycles for performance debug.
- Used between any two pipeline stages (IF/ID, ID/EX, ...).

Parameters:
- DATA_W, 32: payload width in bits.
- PC_W, 32: PC field width in bits.
- SKID_EN, 1: 1 = skid buffer present with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming entries this cycle.
- stall  in  1  hazard hold; the output register must not advance.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept an entry.
- in_pc  in  PC_W  upstream PC.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  held entry valid.
- out_ready  in  1  downstream consumes the entry.
- out_pc  out  PC_W  held PC.
- out_data  out  DATA_W  held payload.
- stall_cnt  out  CNT_W  saturating count of stalled valid cycles.

Behaviour:
- State:
  - Main entry M: m_valid, m_pc, m_data.
  - Skid entry S: s_valid, s_pc, s_data; exists only when SKID_EN=1.
- Outputs are driven directly from M: out_valid = m_valid, out_pc = m_pc, out_data = m_data.
  - Invariant: m_pc and m_data are 0 whenever m_valid=0 (a zero payload is a NOP bubble).
- Reset:
  - Clears m_valid, s_valid, all pc/data fields and stall_cnt.
  - out_* read 0 on the first cycle after reset.
  - Overrides flush, stall and handshakes, including when asserted mid-operation with both entries full.
- Advance condition: adv = !stall && (!m_valid || out_ready).
  - Downstream consumption happens only when m_valid && out_ready && !stall.
  - stall with out_ready=1 still holds M.
- in_ready:
  - SKID_EN=1: in_ready = !s_valid. This is a registered value, with no combinational path from out_ready or stall.
  - SKID_EN=0: in_ready = adv, combinational.
- Accept condition: acc = in_valid && in_ready && !flush.
- Flush (priority below reset, above everything else):
  - Clears m_valid and s_valid and zeroes their fields.
  - The entry offered this cycle is dropped even if in_ready=1.
  - stall is ignored during flush.
- Normal update, when not in reset or flush:
  - adv && s_valid: M <= S, then S <= input if acc, else s_valid <= 0.
  - adv && !s_valid: M <= input if acc, else a bubble (m_valid=0, fields zeroed).
  - !adv && acc: possible only with SKID_EN=1 and S empty; S <= input, M holds.
  - !adv && !acc: M and S hold.
- Ordering is strict FIFO: the S entry always reaches M before any newer input.
- Latency: 1 cycle from accept to out_valid when S is empty.
- Throughput: 1 entry/cycle at steady state with out_ready=1 and stall=0.
- stall_cnt:
  - Increments each cycle with stall && m_valid && !flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset; flush does not clear it.
- Simultaneous events:
  - Consume and accept in the same cycle with S empty: M is replaced and no bubble is inserted.
  - stall deasserts while S is full: M <= S on the next edge, and in_ready goes 1 the cycle after.

Decomposition:
- Shared package pipe_pkg:
  - Default widths PC_W_DEF=32, DATA_W_DEF=32.
  - typedef for the bubble encoding (NOP = 0).
  - Packed struct pipe_entry_t {valid, pc, data}, parametrised via the package defaults.
- One sub-module pipe_skid_slot holds the S entry and its load/clear logic.
  - Instantiated under a generate on SKID_EN; absent when SKID_EN=0.
- The stall counter stays inline.

Test Plan:
- Reset → all outputs 0. Then in_valid=1, pc=0x100, data=0x2002_0005 with out_ready=1 → out_valid=1 with those values on the next cycle, then stream 4 entries at 1/cycle.
- out_ready=1, stall=1 for 3 cycles with M valid (pc=0x104) → M held, stall_cnt=3, in_ready=0 from the 2nd stall cycle (SKID_EN=1). After release, pc=0x104 then pc=0x108 are output in order.
- M and S full (0x200, 0x204), flush=1 with in_valid=1 pc=0x208 → next cycle out_valid=0 and out_pc/out_data=0, in_ready=1, and 0x208 is never output.
- reset asserted mid-stream with S full → next cycle all state and stall_cnt=0, matching the post-reset state of the first scenario.
- CNT_W=4, stall held with M valid for 20 cycles → stall_cnt stops at 15. Repeat with SKID_EN=0: in_ready equals !stall && (!out_valid || out_ready) every cycle.
- Random out_ready/stall/in_valid for 1000 cycles, checked by a scoreboard → FIFO order kept, no loss or duplication, data=0 whenever out_valid=0.
